// File: rtl/serial_bit_tx_if.sv
// Load/parallel-data side and serial line of serial_bit_tx, bundled for port connection.
// dbg_state mirrors the transmitter FSM state register for checkers.
interface serial_bit_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data;
    logic              Load;
    logic              Ready;
    logic              TxD;
    logic              Busy;
    logic              Done;
    logic [2:0]        dbg_state;

    modport master (
        output Data, Load,
        input  Ready, TxD, Busy, Done, dbg_state
    );

    modport slave (
        input  Data, Load,
        output Ready, TxD, Busy, Done, dbg_state
    );
endinterface

// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional even parity
// (enabled by defining SERIAL_BIT_TX_PARITY_EN), stop bit; each bit held BIT_CYCLES clocks.
module serial_bit_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    serial_bit_tx_if.slave  bus
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    // Handshake: a word is accepted on a rising edge where Load=1 and the FSM is IDLE
    // (Ready=1 in the preceding cycle); Load at any other time is ignored, never queued.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_BIT_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              bit_end;
`ifdef SERIAL_BIT_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SERIAL_BIT_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Load) begin
                    shift_d = bus.Data;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
`ifdef SERIAL_BIT_TX_PARITY_EN
                    // Parity accumulates each bit as it leaves the shifter.
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (idx_q == IDX_MAX) begin
                        idx_d = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_BIT_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register on the same edge.
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef SERIAL_BIT_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_STOP) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SERIAL_BIT_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.TxD       = txd_q;
    assign bus.Ready     = ready_q;
    assign bus.Busy      = ~ready_q;
    assign bus.Done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: frame-level reference model plus directed literal frames.
module tb_serial_bit_tx;

  localparam int DW = 8;
  localparam int BC = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + DW + P;
  localparam int F  = NB * BC;
  localparam int F1 = NB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_bit_tx_if #(.DATA_W(DW)) bus0 ();
  serial_bit_tx_if #(.DATA_W(DW)) bus1 ();

  serial_bit_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus0)
  );

  serial_bit_tx #(.DATA_W(DW), .BIT_CYCLES(1)) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  // reference model: one {done, txd} entry per frame cycle
  logic [1:0] exp_q[$];
  logic m_txd = 1'b1;
  logic m_ready = 1'b1;
  logic m_done = 1'b0;

  task automatic push_frame(input logic [DW-1:0] d);
    logic v;
    for (int b = 0; b < NB; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= DW) v = d[b-1];
      else if (P == 1 && b == DW + 1) v = ^d;
      else v = 1'b1;
      for (int c = 0; c < BC; c++)
        exp_q.push_back({(b == NB - 1) && (c == BC - 1), v});
    end
  endtask

  always @(posedge clk) begin
    logic [1:0] e;
    if (rst) begin
      exp_q.delete();
      m_txd = 1'b1; m_ready = 1'b1; m_done = 1'b0;
    end else begin
      if (m_ready && bus0.Load) push_frame(bus0.Data);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m_txd = e[0]; m_done = e[1]; m_ready = 1'b0;
      end else begin
        m_txd = 1'b1; m_done = 1'b0; m_ready = 1'b1;
      end
    end
  end

  // scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic sbit(input string s, input int i);
    return s[i] == 8'h31;
  endfunction

  // advance to the next negedge and compare dut against the model
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("txd",   {15'd0, bus0.TxD},   {15'd0, m_txd});
      check("ready", {15'd0, bus0.Ready}, {15'd0, m_ready});
      check("busy",  {15'd0, bus0.Busy},  {15'd0, !m_ready});
      check("done",  {15'd0, bus0.Done},  {15'd0, m_done});
    end
  endtask

  // driver: mode 0 plain, 1 load+data change mid-frame, 2 reset mid-frame
  task automatic send_frame(input logic [DW-1:0] d, input string es, input int mode);
    int t;
    logic seen;
    t = 0;
    while (!bus0.Ready && t < 500) begin tick(); t++; end
    if (t == 500) check("ready_timeout", 16'd0, 16'd1);
    bus0.Data = d;
    bus0.Load = 1'b1;
    tick();
    bus0.Load = 1'b0;
    bus0.Data = DW'($urandom);
    for (int n = 1; n <= F; n++) begin
      if (mode == 2 && n == 11) begin
        check("rst_txd",   {15'd0, bus0.TxD},   16'd1);
        check("rst_ready", {15'd0, bus0.Ready}, 16'd1);
        check("rst_busy",  {15'd0, bus0.Busy},  16'd0);
        rst = 1'b0;
        break;
      end
      if ((n - 1) % BC == BC / 2)
        check("frame_bit", {15'd0, bus0.TxD}, {15'd0, sbit(es, (n - 1) / BC)});
      if (n == F) check("done_last", {15'd0, bus0.Done}, 16'd1);
      if (n == 10) begin
        if (mode == 1) begin bus0.Load = 1'b1; bus0.Data = ~d; end
        if (mode == 2) rst = 1'b1;
      end
      if (n == 11 && mode == 1) bus0.Load = 1'b0;
      tick();
    end
    if (mode == 2) begin
      seen = 1'b0;
      repeat (F) begin tick(); if (bus0.Done) seen = 1'b1; end
      check("no_done_after_reset", {15'd0, seen}, 16'd0);
    end else begin
      check("ready_after", {15'd0, bus0.Ready}, 16'd1);
      if (mode == 1) begin
        seen = 1'b0;
        repeat (2 * F) begin tick(); if (!bus0.TxD) seen = 1'b1; end
        check("no_second_frame", {15'd0, seen}, 16'd0);
      end
    end
  endtask

  initial begin
    string es_a5, es_07, es_b2b;
`ifdef SERIAL_BIT_TX_PARITY_EN
    es_a5  = "01010010101";
    es_07  = "01110000011";
    es_b2b = "00011110001101100001101";
`else
    es_a5  = "0101001011";
    es_07  = "0111000001";
    es_b2b = "000111100110110000111";
`endif
    rst = 1'b1;
    bus0.Load = 1'b0; bus0.Data = '0;
    bus1.Load = 1'b0; bus1.Data = '0;
    repeat (3) tick();
    check("reset_txd",   {15'd0, bus0.TxD},   16'd1);
    check("reset_ready", {15'd0, bus0.Ready}, 16'd1);
    check("reset_busy",  {15'd0, bus0.Busy},  16'd0);
    check("reset_done",  {15'd0, bus0.Done},  16'd0);
    check("reset_txd1",  {15'd0, bus1.TxD},   16'd1);
    check("reset_state", {13'd0, bus0.dbg_state}, 16'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (20) tick();

    send_frame(8'hA5, es_a5, 0);
    send_frame(8'h07, es_07, 0);
    send_frame(8'hA5, es_a5, 1);
    send_frame(8'h5A, "", 2);

    // back-to-back frames on the single-cycle-bit instance
    bus1.Data = 8'h3C;
    bus1.Load = 1'b1;
    tick();
    bus1.Data = 8'hC3;
    for (int n = 1; n <= 2 * F1 + 1; n++) begin
      check("b2b_bit", {15'd0, bus1.TxD}, {15'd0, sbit(es_b2b, n - 1)});
      if (n == F1) check("b2b_done_a", {15'd0, bus1.Done}, 16'd1);
      if (n == F1 + 1) check("b2b_gap_ready", {15'd0, bus1.Ready}, 16'd1);
      if (n == 2 * F1 + 1) check("b2b_done_b", {15'd0, bus1.Done}, 16'd1);
      if (n == 2 * F1 + 1) bus1.Load = 1'b0;
      tick();
    end
    check("b2b_ready_end", {15'd0, bus1.Ready}, 16'd1);

    // randomized traffic against the model
    repeat (1500) begin
      bus0.Load = ($urandom_range(0, 3) == 0);
      bus0.Data = DW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus0.Load = 1'b0;
    repeat (F + 2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
